// File: rtl/wb_chkpt_port.sv
// Wishbone checkpoint port: queues 16-bit codes and holds each on chk_o for a minimum time.
// Define WB_CHKPT_TSTAMP_EN to add a cycle timestamp of the last pop, readable at 0xC.
module wb_chkpt_port #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter logic [15:0] RESET_VAL   = 16'h0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [3:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [15:0] chk_o,
  output logic [15:0] chk_oeb_o,
  output logic        chk_upd_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic        r_ack;
  logic [31:0] r_dat;
  logic        r_en;
  logic        r_ovf;

  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [LW-1:0] r_lvl;

  logic [0:0]    r_state;
  logic [CW-1:0] r_hcnt;
  logic [15:0]   r_chk;
  logic          r_upd;

  logic        w_req;
  logic        w_wr;
  logic        w_rd;
  logic        w_push;
  logic        w_ctrl;
  logic        w_flush;
  logic        w_empty;
  logic        w_full;
  logic        w_expired;
  logic        w_pop;
  logic        w_accept;
  logic [31:0] w_lvl_ext;
  logic [31:0] w_status;
  logic [31:0] w_reg3;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_req  = wbs_cyc_i & wbs_stb_i & ~r_ack;
  assign w_wr   = w_req & wbs_we_i;
  assign w_rd   = w_req & ~wbs_we_i;
  assign w_push = w_wr & (wbs_adr_i[3:2] == 2'd0)
                & (wbs_sel_i[1:0] == 2'b11);
  assign w_ctrl  = w_wr & (wbs_adr_i[3:2] == 2'd2);
  assign w_flush = w_ctrl & wbs_dat_i[2];

  assign w_empty   = (r_lvl == '0);
  assign w_full    = (r_lvl == LVL_FULL);
  assign w_expired = (r_state == S_IDLE) | (r_hcnt == '0);
  assign w_pop     = ~w_empty & ~w_flush & w_expired;
  // A push into a full queue survives only if the head leaves this edge.
  assign w_accept  = w_push & (~w_full | w_pop);

  assign w_lvl_ext = 32'(r_lvl);
  assign w_status  = {25'h0, r_ovf, (r_state == S_HOLD),
                      w_full, w_empty, w_lvl_ext[2:0]};

  always_ff @(posedge wb_clk_i) begin
    if (w_accept) r_mem[r_wp] <= wbs_dat_i[15:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else if (w_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_accept) r_wp <= r_wp + 1'b1;
      if (w_pop)    r_rp <= r_rp + 1'b1;
      r_lvl <= r_lvl + LW'(w_accept) - LW'(w_pop);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ovf <= 1'b0;
    end else if (w_push & ~w_accept) begin
      r_ovf <= 1'b1;
    end else if (w_ctrl & wbs_dat_i[1]) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_chk   <= RESET_VAL;
      r_upd   <= 1'b0;
    end else begin
      r_upd <= w_pop;
      if (w_pop) begin
        r_chk   <= r_mem[r_rp];
        r_hcnt  <= HOLD_LD;
        r_state <= S_HOLD;
      end else if (r_state == S_HOLD) begin
        if (r_hcnt == '0) r_state <= S_IDLE;
        else              r_hcnt  <= r_hcnt - 1'b1;
      end
    end
  end

`ifdef WB_CHKPT_TSTAMP_EN
  logic [31:0] r_tsc;
  logic [31:0] r_tstamp;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_tsc    <= '0;
      r_tstamp <= '0;
    end else begin
      r_tsc <= r_tsc + 32'd1;
      if (w_pop) r_tstamp <= r_tsc;
    end
  end

  assign w_reg3 = r_tstamp;
`else
  assign w_reg3 = '0;
`endif

  always_comb begin
    w_rdata = '0;
    case (wbs_adr_i[3:2])
      2'd0:    w_rdata = {16'h0, r_chk};
      2'd1:    w_rdata = w_status;
      2'd2:    w_rdata = {31'h0, r_en};
      default: w_rdata = w_reg3;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_en  <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_rd ? w_rdata : 32'h0;
      if (w_ctrl) r_en <= wbs_dat_i[0];
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign chk_o     = r_chk;
  assign chk_upd_o = r_upd;
  assign chk_oeb_o = r_en ? 16'h0000 : 16'hFFFF;

  assign w_unused = &{1'b0, wbs_sel_i[3:2], wbs_adr_i[1:0],
                      wbs_dat_i[31:16], w_lvl_ext[31:3]};
endmodule

// File: tb/tb_wb_chkpt_port.sv
// Bench for wb_chkpt_port: queue-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_chkpt_port;
  localparam int DEPTH = 4;
  localparam int HOLD  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [3:0]  adr = 4'h0;
  logic [31:0] dat_i = 32'h0;
  logic [31:0] dat_o;
  logic        ack;
  logic [15:0] chk;
  logic [15:0] oeb;
  logic        upd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_chkpt_port #(
    .FIFO_DEPTH(DEPTH),
    .HOLD_CYCLES(HOLD),
    .RESET_VAL(16'h0000)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i(we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_i),
    .wbs_dat_o(dat_o),
    .wbs_ack_o(ack),
    .chk_o(chk),
    .chk_oeb_o(oeb),
    .chk_upd_o(upd)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of codes and the cycle of the last pop.
  logic [15:0] q[$];
  logic [15:0] m_chk = 16'h0;
  logic [31:0] m_dat = 32'h0;
  logic [31:0] m_ts  = 32'h0;
  logic [31:0] m_tsc = 32'h0;
  bit m_busy, m_ovf, m_en, m_ack, m_upd, m_valid;
  int m_cyc = 0;
  int m_tpop = 0;

  always @(posedge clk) begin : model
    bit req, wr, pop, fl, push;
    logic [31:0] rd;
    if (rst) begin
      q.delete();
      m_chk = 16'h0; m_dat = '0; m_ts = '0; m_tsc = '0;
      m_busy = 0; m_ovf = 0; m_en = 0; m_ack = 0; m_upd = 0;
      m_valid = 1;
    end else begin
      req  = cyc && stb && !m_ack;
      wr   = req && we;
      push = wr && adr[3:2] == 2'd0 && sel[1:0] == 2'b11;
      fl   = wr && adr[3:2] == 2'd2 && dat_i[2];
      rd   = '0;
      if (req && !we) begin
        case (adr[3:2])
          2'd0: rd = {16'h0, m_chk};
          2'd1: rd = {25'h0, m_ovf, m_busy, q.size() == DEPTH,
                      q.size() == 0, 3'(q.size())};
          2'd2: rd = {31'h0, m_en};
`ifdef WB_CHKPT_TSTAMP_EN
          default: rd = m_ts;
`else
          default: rd = 32'h0;
`endif
        endcase
      end
      pop = q.size() > 0 && !fl && (!m_busy || m_cyc - m_tpop >= HOLD);
      if (pop) begin
        m_chk = q.pop_front();
        m_tpop = m_cyc;
        m_busy = 1;
        m_ts = m_tsc;
      end else if (m_busy && m_cyc - m_tpop >= HOLD) begin
        m_busy = 0;
      end
      if (fl) q.delete();
      if (push) begin
        if (q.size() < DEPTH) q.push_back(dat_i[15:0]);
        else m_ovf = 1;
      end
      if (wr && adr[3:2] == 2'd2) begin
        m_en = dat_i[0];
        if (dat_i[1]) m_ovf = 0;
      end
      m_ack = req;
      m_dat = rd;
      m_upd = pop;
      m_tsc = m_tsc + 1;
    end
    m_cyc++;
  end

  logic [15:0] log_code[$];
  int          log_cyc[$];
  bit          saw_dead = 0;

  always @(negedge clk) begin : compare
    if (m_valid) begin
      check("chk_o", {16'h0, chk}, {16'h0, m_chk});
      check("chk_upd_o", {31'h0, upd}, {31'h0, m_upd});
      check("chk_oeb_o", {16'h0, oeb}, m_en ? 32'h0 : 32'hFFFF);
      check("ack", {31'h0, ack}, {31'h0, m_ack});
      check("dat_o", dat_o, m_dat);
    end
    if (upd) begin
      log_code.push_back(chk);
      log_cyc.push_back(m_cyc);
    end
    if (chk == 16'hDEAD) saw_dead = 1;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic xfer(input logic w, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] r);
    int n;
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
    n = 0; r = '0;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 20);
    if (!ack) begin
      n_tests++; n_fail++;
      $display("FAIL wb_timeout: no ack after %0d cycles adr %h", n, a);
    end else r = dat_o;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    xfer(1'b1, a, d, 4'hF, r);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] r);
    xfer(1'b0, a, 32'h0, 4'hF, r);
  endtask

  initial begin
    logic [31:0] r, t1, t2;
    logic [15:0] c1;
    rst = 1;
    idle(3);
    rst = 0;

    check("rst_chk", {16'h0, chk}, 32'h0);
    check("rst_oeb", {16'h0, oeb}, 32'hFFFF);
    rd(4'h4, r);
    check("rst_status", r, 32'h8);

    wr(4'h8, 32'h1);
    check("en_oeb", {16'h0, oeb}, 32'h0);
    log_code.delete(); log_cyc.delete();
    wr(4'h0, 32'hAB60);
    idle(1);
    check("single_chk", {16'h0, chk}, 32'hAB60);
    check("single_upd", {31'h0, upd}, 32'h1);
    rd(4'h4, r);
    check("single_busy", r, 32'h28);
    idle(20);
    rd(4'h4, r);
    check("single_idle", r, 32'h8);
    check("single_pulses", log_code.size(), 1);

    log_code.delete(); log_cyc.delete();
    for (int i = 1; i <= 5; i++) wr(4'h0, 32'hAB60 + i);
    idle(100);
    check("burst_count", log_code.size(), 5);
    for (int i = 0; i < log_code.size(); i++) begin
      c1 = 16'hAB61 + 16'(i);
      check("burst_code", {16'h0, log_code[i]}, {16'h0, c1});
      if (i > 0) check("burst_hold", log_cyc[i] - log_cyc[i-1], HOLD);
    end
    rd(4'h4, r);
    check("burst_status", r, 32'h8);

    xfer(1'b1, 4'h0, 32'h1234, 4'b1100, r);
    idle(3);
    rd(4'h4, r);
    check("sel_nopush", r, 32'h8);
    check("sel_chk", {16'h0, chk}, 32'hAB65);

    log_code.delete(); log_cyc.delete(); saw_dead = 0;
    wr(4'h0, 32'hAB60);
    wr(4'h0, 32'h1111);
    wr(4'h0, 32'h2222);
    wr(4'h0, 32'h3333);
    wr(4'h0, 32'h4444);
    wr(4'h0, 32'hDEAD);
    rd(4'h4, r);
    check("ovf_full", r, 32'h74);
    idle(100);
    check("ovf_nodead", {31'h0, saw_dead}, 32'h0);
    check("ovf_count", log_code.size(), 5);
    rd(4'h4, r);
    check("ovf_sticky", r, 32'h48);
    wr(4'h8, 32'h3);
    rd(4'h4, r);
    check("ovf_clear", r, 32'h8);

    wr(4'h0, 32'hA001);
    wr(4'h0, 32'hA002);
    wr(4'h0, 32'hA003);
    wr(4'h0, 32'hA004);
    rst = 1;
    idle(2);
    rst = 0;
    check("rst_mid_chk", {16'h0, chk}, 32'h0);
    log_code.delete(); log_cyc.delete();
    idle(40);
    check("rst_mid_noupd", log_code.size(), 0);
    rd(4'h4, r);
    check("rst_mid_status", r, 32'h8);

    wr(4'h8, 32'h1);
    log_code.delete(); log_cyc.delete();
    wr(4'h0, 32'hB001);
    wr(4'h0, 32'hB002);
    wr(4'h0, 32'hB003);
    wr(4'h8, 32'h5);
    rd(4'h4, r);
    check("flush_status", r, 32'h28);
    idle(30);
    check("flush_count", log_code.size(), 1);
    check("flush_chk", {16'h0, chk}, 32'hB001);
    rd(4'h4, r);
    check("flush_idle", r, 32'h8);

`ifdef WB_CHKPT_TSTAMP_EN
    wr(4'h0, 32'hC001);
    wr(4'h0, 32'hC002);
    rd(4'hC, t1);
    idle(20);
    rd(4'hC, t2);
    check("tstamp_delta", t2 - t1, 32'd16);
`else
    rd(4'hC, t1);
    check("reg3_zero", t1, 32'h0);
    t2 = t1;
`endif

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
